// File: rtl/fifo_pkg.sv
// Shared types for the programmable FIFO: read-mode selection.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
// The array is never reset; occupancy tracking lives in the controller.
module fifo_mem #(
    parameter  int WIDTH  = 16,
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store the incoming word on an accepted write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_prog.sv
// Programmable-threshold synchronous FIFO with standard or first-word
// fall-through read mode. Pointers wrap by explicit compare so any depth
// from 2 upward works, not just powers of two.
module fifo_prog
    import fifo_pkg::*;
#(
    parameter  int         FIFO_WIDTH = 16,
    parameter  int         FIFO_DEPTH = 8,
    parameter  fifo_mode_e MODE       = FIFO_STD,
    localparam int         CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [CNT_W-1:0]      af_level,
    input  logic [CNT_W-1:0]      ae_level,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CNT_W-1:0]      count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr_next;
    logic [PTR_W-1:0]      rd_ptr_next;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [FIFO_WIDTH-1:0] rd_data;
    logic [FIFO_WIDTH-1:0] data_q;

    // Status flags derive purely from occupancy and the threshold inputs.
    assign full        = (count == FULL_CNT);
    assign empty       = (count == '0);
    assign almostfull  = (count >= af_level);
    assign almostempty = (count <= ae_level);

    // Flush blocks both ports so nothing lands in memory or moves a pointer.
    assign wr_accept = wr_en && !full  && !flush;
    assign rd_accept = rd_en && !empty && !flush;

    assign wr_ptr_next = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
    assign rd_ptr_next = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;

    fifo_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // Pointer, occupancy and one-cycle handshake pulse bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_accept;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
            if (wr_accept) begin
                wr_ptr <= wr_ptr_next;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr_next;
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output word register: in standard mode it is the read result; in
    // fall-through mode it remembers the last visible head so data_out
    // holds steady once the FIFO drains or is flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (rd_accept) begin
            data_q <= rd_data;
        end else if (MODE == FIFO_FWFT && flush && !empty) begin
            data_q <= rd_data;
        end
    end

    assign data_out = (MODE == FIFO_FWFT && !empty) ? rd_data : data_q;

endmodule

// File: tb/tb_fifo_prog.sv
// Directed self-checking bench for fifo_prog: a depth-8 standard-mode
// instance and a depth-5 fall-through instance share clock and reset.
module tb_fifo_prog;
    import fifo_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          compared = 0;
    int          mismatched = 0;

    logic        s_flush = 1'b0, s_wr_en = 1'b0, s_rd_en = 1'b0;
    logic [15:0] s_data_in = '0, s_data_out;
    logic [3:0]  s_af = 4'd6, s_ae = 4'd2, s_count;
    logic        s_wr_ack, s_overflow, s_underflow, s_full, s_empty, s_afull, s_aempty;

    logic        f_flush = 1'b0, f_wr_en = 1'b0, f_rd_en = 1'b0;
    logic [15:0] f_data_in = '0, f_data_out;
    logic [2:0]  f_af = 3'd4, f_ae = 3'd1, f_count;
    logic        f_wr_ack, f_overflow, f_underflow, f_full, f_empty, f_afull, f_aempty;

    fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .MODE(FIFO_STD)) u_std (
        .clk(clk), .rst_n(rst_n), .flush(s_flush), .data_in(s_data_in),
        .wr_en(s_wr_en), .rd_en(s_rd_en), .af_level(s_af), .ae_level(s_ae),
        .data_out(s_data_out), .wr_ack(s_wr_ack), .overflow(s_overflow),
        .underflow(s_underflow), .full(s_full), .empty(s_empty),
        .almostfull(s_afull), .almostempty(s_aempty), .count(s_count)
    );

    fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .MODE(FIFO_FWFT)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(f_flush), .data_in(f_data_in),
        .wr_en(f_wr_en), .rd_en(f_rd_en), .af_level(f_af), .ae_level(f_ae),
        .data_out(f_data_out), .wr_ack(f_wr_ack), .overflow(f_overflow),
        .underflow(f_underflow), .full(f_full), .empty(f_empty),
        .almostfull(f_afull), .almostempty(f_aempty), .count(f_count)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        compared++; if (s_count !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_count: got %0d, expected 0", s_count); end
        compared++; if (s_empty !== 1'b1 || s_full !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_flags: got empty=%b full=%b, expected 1 0", s_empty, s_full); end
        compared++; if (s_data_out !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_data: got %h, expected 0000", s_data_out); end
        compared++; if ({s_wr_ack, s_overflow, s_underflow} !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_pulses: got %b, expected 000", {s_wr_ack, s_overflow, s_underflow}); end
        compared++; if (f_empty !== 1'b1 || f_data_out !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_fwft: got empty=%b data=%h, expected 1 0000", f_empty, f_data_out); end
        #6 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            s_wr_en = 1'b1; s_data_in = 16'(i);
            tick();
            compared++; if (s_wr_ack !== 1'b1) begin mismatched++; $display("[TB] FAIL fill_ack[%0d]: got %b, expected 1", i, s_wr_ack); end
            compared++; if (s_count !== 4'(i)) begin mismatched++; $display("[TB] FAIL fill_count[%0d]: got %0d, expected %0d", i, s_count, i); end
            compared++; if (s_afull !== (i >= 6)) begin mismatched++; $display("[TB] FAIL fill_afull[%0d]: got %b, expected %b", i, s_afull, i >= 6); end
            compared++; if (s_full !== (i == 8)) begin mismatched++; $display("[TB] FAIL fill_full[%0d]: got %b, expected %b", i, s_full, i == 8); end
        end
        s_wr_en = 1'b0;
        tick();
        compared++; if (s_wr_ack !== 1'b0 || s_count !== 4'd8) begin mismatched++; $display("[TB] FAIL fill_idle: got ack=%b count=%0d, expected 0 8", s_wr_ack, s_count); end
    endtask

    task automatic test_full_rw();
        s_wr_en = 1'b1; s_rd_en = 1'b1; s_data_in = 16'hBEEF;
        tick();
        s_wr_en = 1'b0; s_rd_en = 1'b0;
        compared++; if (s_overflow !== 1'b1 || s_wr_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL full_rw_pulse: got ovf=%b ack=%b, expected 1 0", s_overflow, s_wr_ack); end
        compared++; if (s_count !== 4'd7 || s_full !== 1'b0) begin mismatched++; $display("[TB] FAIL full_rw_count: got %0d full=%b, expected 7 0", s_count, s_full); end
        compared++; if (s_data_out !== 16'h0001) begin mismatched++; $display("[TB] FAIL full_rw_data: got %h, expected 0001", s_data_out); end
        tick();
        compared++; if (s_overflow !== 1'b0 || s_data_out !== 16'h0001) begin mismatched++; $display("[TB] FAIL full_rw_hold: got ovf=%b data=%h, expected 0 0001", s_overflow, s_data_out); end
    endtask

    task automatic test_empty_rw();
        for (int k = 1; k <= 7; k++) begin
            s_rd_en = 1'b1;
            tick();
            compared++; if (s_data_out !== 16'(k + 1) || s_count !== 4'(7 - k)) begin mismatched++; $display("[TB] FAIL drain[%0d]: got data=%h count=%0d, expected %h %0d", k, s_data_out, s_count, 16'(k + 1), 7 - k); end
        end
        s_rd_en = 1'b0;
        tick();
        compared++; if (s_empty !== 1'b1 || s_underflow !== 1'b0) begin mismatched++; $display("[TB] FAIL drained: got empty=%b udf=%b, expected 1 0", s_empty, s_underflow); end
        s_wr_en = 1'b1; s_rd_en = 1'b1; s_data_in = 16'h00AA;
        tick();
        s_wr_en = 1'b0;
        compared++; if (s_underflow !== 1'b1 || s_wr_ack !== 1'b1 || s_count !== 4'd1) begin mismatched++; $display("[TB] FAIL empty_rw: got udf=%b ack=%b count=%0d, expected 1 1 1", s_underflow, s_wr_ack, s_count); end
        tick();
        compared++; if (s_data_out !== 16'h00AA || s_count !== 4'd0 || s_underflow !== 1'b0) begin mismatched++; $display("[TB] FAIL empty_rw_read: got data=%h count=%0d udf=%b, expected 00aa 0 0", s_data_out, s_count, s_underflow); end
        tick();
        s_rd_en = 1'b0;
        compared++; if (s_underflow !== 1'b1 || s_data_out !== 16'h00AA) begin mismatched++; $display("[TB] FAIL empty_read: got udf=%b data=%h, expected 1 00aa", s_underflow, s_data_out); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            s_wr_en = 1'b1; s_data_in = 16'h0010 + 16'(i);
            tick();
        end
        compared++; if (s_count !== 4'd5) begin mismatched++; $display("[TB] FAIL flush_pre: got %0d, expected 5", s_count); end
        s_flush = 1'b1; s_data_in = 16'h0099;
        tick();
        s_flush = 1'b0; s_wr_en = 1'b0;
        compared++; if (s_count !== 4'd0 || s_empty !== 1'b1 || s_wr_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL flush: got count=%0d empty=%b ack=%b, expected 0 1 0", s_count, s_empty, s_wr_ack); end
        compared++; if (s_aempty !== 1'b1 || s_data_out !== 16'h00AA) begin mismatched++; $display("[TB] FAIL flush_misc: got aempty=%b data=%h, expected 1 00aa", s_aempty, s_data_out); end
        s_wr_en = 1'b1; s_data_in = 16'h0055;
        tick();
        s_wr_en = 1'b0; s_rd_en = 1'b1;
        tick();
        s_rd_en = 1'b0;
        compared++; if (s_data_out !== 16'h0055 || s_count !== 4'd0) begin mismatched++; $display("[TB] FAIL flush_after: got data=%h count=%0d, expected 0055 0", s_data_out, s_count); end
    endtask

    task automatic test_fwft_wrap();
        for (int k = 0; k < 12; k++) begin
            f_wr_en = 1'b1; f_data_in = 16'h0100 + 16'(k);
            tick();
            f_wr_en = 1'b0; f_rd_en = 1'b1;
            compared++; if (f_data_out !== 16'h0100 + 16'(k) || f_count !== 3'd1) begin mismatched++; $display("[TB] FAIL fwft_head[%0d]: got data=%h count=%0d, expected %h 1", k, f_data_out, f_count, 16'h0100 + 16'(k)); end
            compared++; if (f_wr_ack !== 1'b1 || f_empty !== 1'b0) begin mismatched++; $display("[TB] FAIL fwft_wr[%0d]: got ack=%b empty=%b, expected 1 0", k, f_wr_ack, f_empty); end
            tick();
            f_rd_en = 1'b0;
            compared++; if (f_count !== 3'd0 || f_overflow !== 1'b0 || f_underflow !== 1'b0) begin mismatched++; $display("[TB] FAIL fwft_pop[%0d]: got count=%0d ovf=%b udf=%b, expected 0 0 0", k, f_count, f_overflow, f_underflow); end
            compared++; if (f_data_out !== 16'h0100 + 16'(k)) begin mismatched++; $display("[TB] FAIL fwft_hold[%0d]: got %h, expected %h", k, f_data_out, 16'h0100 + 16'(k)); end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            s_wr_en = 1'b1; s_data_in = 16'h0021 + 16'(i);
            tick();
        end
        s_data_in = 16'h0024;
        compared++; if (s_count !== 4'd3 || s_wr_ack !== 1'b1) begin mismatched++; $display("[TB] FAIL burst_pre: got count=%0d ack=%b, expected 3 1", s_count, s_wr_ack); end
        #2 rst_n = 1'b0;
        #1;
        compared++; if (s_count !== 4'd0 || s_empty !== 1'b1 || s_full !== 1'b0) begin mismatched++; $display("[TB] FAIL async_rst_count: got count=%0d empty=%b full=%b, expected 0 1 0", s_count, s_empty, s_full); end
        compared++; if (s_data_out !== 16'h0000 || s_wr_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL async_rst_out: got data=%h ack=%b, expected 0000 0", s_data_out, s_wr_ack); end
        s_wr_en = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        compared++; if (s_count !== 4'd0 || s_wr_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL async_rst_after: got count=%0d ack=%b, expected 0 0", s_count, s_wr_ack); end
    endtask

    initial begin
        test_reset();
        test_fwft_wrap();
        test_fill();
        test_full_rw();
        test_empty_rw();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fifo_prog.md
FIFO_PROG -- requirements
Module: fifo_prog

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16, data word width in bits (1..64).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, number of entries (any value 2..1024; power of two not required).
REQ-003 SHALL have parameter MODE, default FIFO_STD, read mode: FIFO_STD (registered read) or FIFO_FWFT (first-word fall-through).
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk, rst_n.
REQ-005 SHALL have ports (name  direction  width  meaning), clock and reset first:
 clk  in  1  single clock, rising edge
 rst_n  in  1  async active-low reset
 flush  in  1  sync clear of contents
 data_in  in  FIFO_WIDTH  write data
 wr_en  in  1  write request
 rd_en  in  1  read request
 af_level  in  CNT_W  almost-full threshold
 ae_level  in  CNT_W  almost-empty threshold
 data_out  out  FIFO_WIDTH  read data
 wr_ack  out  1  registered: previous write accepted
 overflow  out  1  registered: previous write rejected
 underflow  out  1  registered: previous read rejected
 full, empty, almostfull, almostempty  out  1 each  status
 count  out  CNT_W  current occupancy
REQ-006 SHALL define CNT_W = $clog2(FIFO_DEPTH+1).

Function
REQ-007 SHALL accept a write when wr_en=1 and full=0; store data_in at write pointer, increment pointer.
REQ-008 SHALL accept a read when rd_en=1 and empty=0; advance read pointer.
REQ-009 SHALL wrap each pointer from FIFO_DEPTH-1 to 0 (explicit compare, not modulo-2^n).
REQ-010 SHALL update count: +1 write only, -1 read only, unchanged when both accepted or neither.
REQ-011 SHALL, when full with wr_en=rd_en=1, accept the read, reject the write (overflow=1 next cycle, count becomes DEPTH-1).
REQ-012 SHALL, when empty with wr_en=rd_en=1, accept the write, reject the read (underflow=1 next cycle, count becomes 1).
REQ-013 SHALL register wr_ack/overflow/underflow one cycle after the request; each held only one cycle per request.
REQ-014 SHALL drive full=(count==FIFO_DEPTH), empty=(count==0), combinationally from count.
REQ-015 SHALL drive almostfull=(count>=af_level), almostempty=(count<=ae_level), unsigned compare, combinational; af_level=0 forces almostfull=1.
REQ-016 SHALL, in FIFO_STD, present the read word on data_out the cycle after an accepted read and hold data_out otherwise.
REQ-017 SHALL, in FIFO_FWFT, present the head entry on data_out whenever empty=0 (zero-latency); rd_en pops it; data_out holds last value when empty.
REQ-018 SHALL treat flush=1 as priority over wr_en/rd_en: next cycle pointers=0, count=0, wr_ack/overflow/underflow=0; data_out unchanged; memory not cleared.

Reset
REQ-019 SHALL, on rst_n=0 (asynchronous), set pointers=0, count=0, data_out=0, wr_ack=0, overflow=0, underflow=0 (hence empty=1, full=0).
REQ-020 SHALL discard any in-flight operation when reset asserts mid-transfer; memory array is not reset.
REQ-021 SHALL release reset synchronously to the first clk edge with rst_n=1 (synchroniser external).

Structure
REQ-022 SHALL place enum fifo_mode_e {FIFO_STD, FIFO_FWFT} in shared package fifo_pkg.
REQ-023 SHALL instantiate one sub-module fifo_mem: FIFO_DEPTH x FIFO_WIDTH, one sync write port, one async read port; control and status in fifo_prog.

Verification
REQ-024 Reset then 8 writes (0x0001..0x0008), DEPTH=8, af_level=6 -> wr_ack each cycle after write, almostfull rises at count=6, full=1 after 8th, count=8.
REQ-025 Full FIFO, wr_en=rd_en=1 data 0xBEEF -> overflow=1, wr_ack=0, count=7, data_out=0x0001 (STD, next cycle).
REQ-026 Empty FIFO, wr_en=rd_en=1 data 0x00AA -> underflow=1, wr_ack=1, count=1; next read returns 0x00AA.
REQ-027 FWFT, DEPTH=5, 12 write/read pairs -> data_out equals written word same cycle as pop, pointers wrap 4->0, no overflow/underflow.
REQ-028 count=5, flush=1 with wr_en=1 -> next cycle count=0, empty=1, wr_ack=0; ae_level=2 gives almostempty=1.
REQ-029 rst_n asserted mid-burst (count=3) asynchronously -> outputs at reset values before next clk edge.
